// File: rtl/compare_demo.sv
// compare_demo
//   Registered three-way magnitude comparator with saturating per-outcome
//   event counters. Flags and counters update on every rising clk edge; a
//   low rst_n at an edge clears all state.
//
// Ports
//   clk     in   sole clock, rising edge
//   rst_n   in   synchronous active-low reset
//   x, y    in   WIDTH-bit operands (unsigned or two's complement)
//   xgy     out  registered x > y
//   xey     out  registered x == y
//   xsy     out  registered x < y
//   gt_cnt  out  saturating count of x > y samples
//   eq_cnt  out  saturating count of x == y samples
//   lt_cnt  out  saturating count of x < y samples

module compare_demo #(
  parameter int WIDTH      = 3,
  parameter int SIGNED_CMP = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             xgy,
  output logic             xey,
  output logic             xsy,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic w_gt;
  logic w_eq;
  logic w_lt;

  logic             r_xgy;
  logic             r_xey;
  logic             r_xsy;
  logic [CNT_W-1:0] r_gt_cnt;
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_lt_cnt;

  generate
    if (SIGNED_CMP != 0) begin : g_signed
      assign w_gt = $signed(x) > $signed(y);
    end else begin : g_unsigned
      assign w_gt = x > y;
    end
  endgenerate

  // Equality is a plain bit match in both modes; "less" is derived from the
  // other two so the three results are one-hot by construction.
  assign w_eq = (x == y);
  assign w_lt = ~w_gt & ~w_eq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xgy    <= 1'b0;
      r_xey    <= 1'b0;
      r_xsy    <= 1'b0;
      r_gt_cnt <= '0;
      r_eq_cnt <= '0;
      r_lt_cnt <= '0;
    end else begin
      r_xgy <= w_gt;
      r_xey <= w_eq;
      r_xsy <= w_lt;
      // Each counter saturates on its own; the others keep counting.
      if (w_gt && (r_gt_cnt != CNT_MAX)) r_gt_cnt <= r_gt_cnt + CNT_ONE;
      if (w_eq && (r_eq_cnt != CNT_MAX)) r_eq_cnt <= r_eq_cnt + CNT_ONE;
      if (w_lt && (r_lt_cnt != CNT_MAX)) r_lt_cnt <= r_lt_cnt + CNT_ONE;
    end
  end

  assign xgy    = r_xgy;
  assign xey    = r_xey;
  assign xsy    = r_xsy;
  assign gt_cnt = r_gt_cnt;
  assign eq_cnt = r_eq_cnt;
  assign lt_cnt = r_lt_cnt;

endmodule

// File: tb/tb_compare_demo.sv
// tb_compare_demo
//   Drives three comparator instances from shared operands: unsigned with
//   16-bit counters, signed with 16-bit counters, unsigned with 3-bit
//   counters. Stimulus pushes expected results into a queue; a monitor pops
//   one entry after every sampled edge and compares.

module tb_compare_demo;

  logic       clk;
  logic       rst_n;
  logic [2:0] x;
  logic [2:0] y;

  logic        u_gt, u_eq, u_lt;
  logic [15:0] u_gc, u_ec, u_lc;
  logic        s_gt, s_eq, s_lt;
  logic [15:0] s_gc, s_ec, s_lc;
  logic        a_gt, a_eq, a_lt;
  logic [2:0]  a_gc, a_ec, a_lc;

  compare_demo #(.WIDTH(3), .SIGNED_CMP(0), .CNT_W(16)) u_uns (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .xgy(u_gt), .xey(u_eq), .xsy(u_lt),
    .gt_cnt(u_gc), .eq_cnt(u_ec), .lt_cnt(u_lc)
  );

  compare_demo #(.WIDTH(3), .SIGNED_CMP(1), .CNT_W(16)) u_sgn (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .xgy(s_gt), .xey(s_eq), .xsy(s_lt),
    .gt_cnt(s_gc), .eq_cnt(s_ec), .lt_cnt(s_lc)
  );

  compare_demo #(.WIDTH(3), .SIGNED_CMP(0), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .xgy(a_gt), .xey(a_eq), .xsy(a_lt),
    .gt_cnt(a_gc), .eq_cnt(a_ec), .lt_cnt(a_lc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] xv;
    logic [2:0] yv;
    logic [2:0] uf;
    int         ug, ue, ul;
    logic [2:0] sf;
    int         sg, se, sl;
    logic [2:0] af;
    int         ag, ae, al;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // model counter state
  int m_ug, m_ue, m_ul;
  int m_sg, m_se, m_sl;
  int m_ag, m_ae, m_al;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int lim);
    return (v < lim) ? v + 1 : v;
  endfunction

  // One sample: drive operands/reset before the edge and queue the expected
  // post-edge state.
  task automatic issue(input logic r, input logic [2:0] xv, input logic [2:0] yv);
    exp_t e;
    int sx, sy;
    @(negedge clk);
    rst_n = r;
    x = xv;
    y = yv;
    e.xv = xv;
    e.yv = yv;
    if (!r) begin
      m_ug = 0; m_ue = 0; m_ul = 0;
      m_sg = 0; m_se = 0; m_sl = 0;
      m_ag = 0; m_ae = 0; m_al = 0;
      e.uf = 3'b000;
      e.sf = 3'b000;
      e.af = 3'b000;
    end else begin
      sx = (xv >= 4) ? int'(xv) - 8 : int'(xv);
      sy = (yv >= 4) ? int'(yv) - 8 : int'(yv);
      if (xv > yv)       begin e.uf = 3'b100; m_ug = sat_inc(m_ug, 65535); m_ag = sat_inc(m_ag, 7); end
      else if (xv == yv) begin e.uf = 3'b010; m_ue = sat_inc(m_ue, 65535); m_ae = sat_inc(m_ae, 7); end
      else               begin e.uf = 3'b001; m_ul = sat_inc(m_ul, 65535); m_al = sat_inc(m_al, 7); end
      e.af = e.uf;
      if (sx > sy)       begin e.sf = 3'b100; m_sg = sat_inc(m_sg, 65535); end
      else if (sx == sy) begin e.sf = 3'b010; m_se = sat_inc(m_se, 65535); end
      else               begin e.sf = 3'b001; m_sl = sat_inc(m_sl, 65535); end
    end
    e.ug = m_ug; e.ue = m_ue; e.ul = m_ul;
    e.sg = m_sg; e.se = m_se; e.sl = m_sl;
    e.ag = m_ag; e.ae = m_ae; e.al = m_al;
    q.push_back(e);
  endtask

  // monitor: every edge, compare against the entry queued for it
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("uns_flags x=%0d y=%0d", e.xv, e.yv), int'({u_gt, u_eq, u_lt}), int'(e.uf));
      chk("uns_gt_cnt", int'(u_gc), e.ug);
      chk("uns_eq_cnt", int'(u_ec), e.ue);
      chk("uns_lt_cnt", int'(u_lc), e.ul);
      chk($sformatf("sgn_flags x=%0d y=%0d", e.xv, e.yv), int'({s_gt, s_eq, s_lt}), int'(e.sf));
      chk("sgn_gt_cnt", int'(s_gc), e.sg);
      chk("sgn_eq_cnt", int'(s_ec), e.se);
      chk("sgn_lt_cnt", int'(s_lc), e.sl);
      chk($sformatf("sat_flags x=%0d y=%0d", e.xv, e.yv), int'({a_gt, a_eq, a_lt}), int'(e.af));
      chk("sat_gt_cnt", int'(a_gc), e.ag);
      chk("sat_eq_cnt", int'(a_ec), e.ae);
      chk("sat_lt_cnt", int'(a_lc), e.al);
    end
  end

  // hand-computed spot checks, taken just after the edge of the last issue
  task automatic spot(input string name, input int act, input int exp);
    chk(name, act, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    x = 3'd7;
    y = 3'd0;

    // reset held for two edges with x=7, y=0
    issue(1'b0, 3'd7, 3'd0);
    issue(1'b0, 3'd7, 3'd0);
    @(posedge clk); #2;
    spot("reset_flags", int'({u_gt, u_eq, u_lt}), 0);
    spot("reset_gt_cnt", int'(u_gc), 0);
    issue(1'b1, 3'd7, 3'd0);
    @(posedge clk); #2;
    spot("first_xgy", int'(u_gt), 1);
    spot("first_gt_cnt", int'(u_gc), 1);

    // nine more samples (ten total), then a one-edge reset pulse
    for (int i = 0; i < 9; i++) issue(1'b1, 3'(i), 3'(8 - i));
    issue(1'b0, 3'd5, 3'd1);
    @(posedge clk); #2;
    spot("midrst_eq_cnt", int'(u_ec), 0);
    spot("midrst_flags", int'({u_gt, u_eq, u_lt}), 0);
    issue(1'b1, 3'd5, 3'd1);
    @(posedge clk); #2;
    spot("resume_gt_cnt", int'(u_gc), 1);

    // exhaustive unsigned sweep from a clean reset
    issue(1'b0, 3'd0, 3'd0);
    for (int i = 0; i < 64; i++) issue(1'b1, 3'(i), 3'(i >> 3));
    @(posedge clk); #2;
    spot("sweep_gt_cnt", int'(u_gc), 28);
    spot("sweep_eq_cnt", int'(u_ec), 8);
    spot("sweep_lt_cnt", int'(u_lc), 28);

    // signed directed vectors
    issue(1'b1, 3'b111, 3'b001);
    @(posedge clk); #2;
    spot("sgn_m1_lt_1", int'(s_lt), 1);
    issue(1'b1, 3'b011, 3'b100);
    @(posedge clk); #2;
    spot("sgn_3_gt_m4", int'(s_gt), 1);
    issue(1'b1, 3'b100, 3'b100);
    @(posedge clk); #2;
    spot("sgn_m4_eq", int'(s_eq), 1);

    // saturation on the 3-bit counter instance
    issue(1'b0, 3'd2, 3'd2);
    for (int i = 0; i < 10; i++) issue(1'b1, 3'd2, 3'd2);
    @(posedge clk); #2;
    spot("sat_eq_hold", int'(a_ec), 7);
    spot("sat_gt_zero", int'(a_gc), 0);
    spot("sat_lt_zero", int'(a_lc), 0);

    // latency: x toggles 0/7 every cycle against y=4
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, (i % 2 == 0) ? 3'd0 : 3'd7, 3'd4);
      @(posedge clk); #2;
      spot("latency_xgy", int'(u_gt), (i % 2 == 0) ? 0 : 1);
    end

    @(posedge clk); #3;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
